// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: I-side, D-side and memory-port signals of the memory arbiter
// Ports: master = arbiter view (drives responses and memory port),
//        slave  = requester/memory view (drives requests and mem_rdata).
interface mem_arbiter_if #(parameter int DATA_W = 32);
  logic              i_req, i_flush, i_done;
  logic [DATA_W-1:0] i_addr, i_rdata;
  logic              d_req, d_we, d_done;
  logic [DATA_W-1:0] d_addr, d_wdata, d_rdata;
  logic [3:0]        d_wstrb;
  logic              mem_en, mem_we, busy;
  logic [DATA_W-1:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]        mem_wstrb;
  modport master (
    input  i_req, i_addr, i_flush, d_req, d_we, d_addr, d_wdata, d_wstrb, mem_rdata,
    output i_rdata, i_done, d_rdata, d_done, mem_en, mem_we, mem_addr, mem_wdata, mem_wstrb, busy
  );
  modport slave (
    output i_req, i_addr, i_flush, d_req, d_we, d_addr, d_wdata, d_wstrb, mem_rdata,
    input  i_rdata, i_done, d_rdata, d_done, mem_en, mem_we, mem_addr, mem_wdata, mem_wstrb, busy
  );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin I/D arbiter for a single fixed-latency memory port
// Ports: clk, rst (async, active-high); bus (master modport) carries the I-side
//        read/flush/response, the D-side load/store/response and the memory port.
module mem_arbiter #(
  parameter int MEM_LAT = 2,
  parameter int DATA_W  = 32
) (
  input logic clk,
  input logic rst,
  mem_arbiter_if.master bus
);
  localparam int CW = $clog2(MEM_LAT + 1);
  typedef enum logic [1:0] {IDLE, I_BUSY, D_BUSY} state_t;
  state_t state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic last, last_n, kill, kill_n, en, en_n, we, we_n;
  logic idone, idone_n, ddone, ddone_n;
  logic [DATA_W-1:0] addr, addr_n, wdata, wdata_n, ir, ir_n, dr, dr_n;
  logic [3:0] wstrb, wstrb_n;
  logic ei, ed, pick_d, last_beat, kill_eff;
  // A side whose done pulse is high this cycle is still dropping its request.
  assign ei = bus.i_req & ~bus.i_flush & ~idone;
  assign ed = bus.d_req & ~ddone;
  // last=1 means D won the previous grant, so contention goes to I.
  assign pick_d = ed & (~ei | ~last);
  assign last_beat = cnt == CW'(MEM_LAT - 1);
  // A flush in the final busy cycle still kills the fetch.
  assign kill_eff = kill | bus.i_flush;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      last  <= 1'b0;
      kill  <= 1'b0;
      en    <= 1'b0;
      we    <= 1'b0;
      addr  <= '0;
      wdata <= '0;
      wstrb <= '0;
      ir    <= '0;
      dr    <= '0;
      idone <= 1'b0;
      ddone <= 1'b0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      last  <= last_n;
      kill  <= kill_n;
      en    <= en_n;
      we    <= we_n;
      addr  <= addr_n;
      wdata <= wdata_n;
      wstrb <= wstrb_n;
      ir    <= ir_n;
      dr    <= dr_n;
      idone <= idone_n;
      ddone <= ddone_n;
    end
  end
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    last_n  = last;
    kill_n  = kill;
    en_n    = en;
    we_n    = we;
    addr_n  = addr;
    wdata_n = wdata;
    wstrb_n = wstrb;
    ir_n    = ir;
    dr_n    = dr;
    idone_n = 1'b0;
    ddone_n = 1'b0;
    case (state)
      IDLE: if (ei | ed) begin
        state_n = pick_d ? D_BUSY : I_BUSY;
        last_n  = pick_d;
        cnt_n   = '0;
        kill_n  = 1'b0;
        en_n    = 1'b1;
        we_n    = pick_d & bus.d_we;
        addr_n  = (pick_d ? bus.d_addr : bus.i_addr) & ~DATA_W'(3);
        wdata_n = pick_d ? bus.d_wdata : '0;
        wstrb_n = pick_d ? bus.d_wstrb : '0;
      end
      I_BUSY: if (!last_beat) begin
        cnt_n  = cnt + CW'(1);
        kill_n = kill_eff;
      end else begin
        state_n = IDLE;
        en_n    = 1'b0;
        kill_n  = 1'b0;
        idone_n = ~kill_eff;
        ir_n    = kill_eff ? ir : bus.mem_rdata;
      end
      D_BUSY: if (!we && !last_beat) begin
        cnt_n = cnt + CW'(1);
      end else begin
        state_n = IDLE;
        en_n    = 1'b0;
        we_n    = 1'b0;
        ddone_n = 1'b1;
        dr_n    = we ? dr : bus.mem_rdata;
      end
      default: state_n = IDLE;
    endcase
  end
  assign bus.mem_en    = en;
  assign bus.mem_we    = we;
  assign bus.mem_addr  = addr;
  assign bus.mem_wdata = wdata;
  assign bus.mem_wstrb = wstrb;
  assign bus.i_rdata   = ir;
  assign bus.i_done    = idone;
  assign bus.d_rdata   = dr;
  assign bus.d_done    = ddone;
  assign bus.busy      = state != IDLE;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed self-checking bench for mem_arbiter with MEM_LAT=2
module tb_mem_arbiter;
  localparam logic [31:0] K = 32'hA5A5_0000;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic use_model = 1'b0;
  logic [31:0] mem_val = '0;
  int total = 0;
  int bad = 0;
  mem_arbiter_if #(.DATA_W(32)) bus();
  mem_arbiter #(.MEM_LAT(2), .DATA_W(32)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  assign bus.mem_rdata = use_model ? (bus.mem_addr ^ K) : mem_val;
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic test_reset();
    bus.i_req = 0; bus.i_addr = 0; bus.i_flush = 0;
    bus.d_req = 0; bus.d_we = 0; bus.d_addr = 0; bus.d_wdata = 0; bus.d_wstrb = 0;
    rst = 1;
    step(); step();
    total++;
    if ({bus.mem_en, bus.mem_we, bus.mem_addr, bus.mem_wdata, bus.mem_wstrb} !== 70'd0) begin
      bad++; $display("FAIL reset_mem got %h want 0", {bus.mem_en, bus.mem_we, bus.mem_addr, bus.mem_wdata, bus.mem_wstrb});
    end
    total++;
    if ({bus.i_rdata, bus.d_rdata, bus.i_done, bus.d_done, bus.busy} !== 67'd0) begin
      bad++; $display("FAIL reset_resp got %h want 0", {bus.i_rdata, bus.d_rdata, bus.i_done, bus.d_done, bus.busy});
    end
    rst = 0;
    step();
    total++;
    if ({bus.busy, bus.mem_en} !== 2'b00) begin
      bad++; $display("FAIL reset_idle got %b want 00", {bus.busy, bus.mem_en});
    end
  endtask
  task automatic test_i_read();
    bus.i_req = 1; bus.i_addr = 32'h1006; mem_val = 32'hDEADBEEF;
    for (int k = 1; k <= 4; k++) begin
      step();
      total++;
      if ({bus.mem_en, bus.i_done, bus.busy} !== ((k <= 2) ? 3'b101 : (k == 3) ? 3'b010 : 3'b000)) begin
        bad++; $display("FAIL i_read_ctl cyc%0d got %b want %b", k, {bus.mem_en, bus.i_done, bus.busy},
                        (k <= 2) ? 3'b101 : (k == 3) ? 3'b010 : 3'b000);
      end
      if (k == 1) begin
        total++;
        if ({bus.mem_addr, bus.mem_we, bus.mem_wstrb} !== {32'h1004, 1'b0, 4'h0}) begin
          bad++; $display("FAIL i_read_addr got %h/%b/%h want 1004/0/0", bus.mem_addr, bus.mem_we, bus.mem_wstrb);
        end
      end
      if (k == 3) begin
        total++;
        if (bus.i_rdata !== 32'hDEADBEEF) begin
          bad++; $display("FAIL i_read_data got %h want deadbeef", bus.i_rdata);
        end
        bus.i_req = 0;
      end
    end
  endtask
  task automatic test_flush();
    bus.i_req = 1; bus.i_addr = 32'h2000; mem_val = 32'hBAD0BAD0;
    step();
    total++;
    if ({bus.mem_en, bus.busy} !== 2'b11) begin
      bad++; $display("FAIL flush_grant got %b want 11", {bus.mem_en, bus.busy});
    end
    bus.i_flush = 1; bus.i_req = 0;
    step();
    bus.i_flush = 0;
    total++;
    if ({bus.mem_en, bus.busy, bus.mem_addr} !== {2'b11, 32'h2000}) begin
      bad++; $display("FAIL flush_runs got %h want 3_00002000", {bus.mem_en, bus.busy, bus.mem_addr});
    end
    for (int k = 0; k < 2; k++) begin
      step();
      total++;
      if ({bus.i_done, bus.mem_en, bus.busy, bus.i_rdata} !== {3'b000, 32'hDEADBEEF}) begin
        bad++; $display("FAIL flush_killed cyc%0d got %h want 0_deadbeef", k, {bus.i_done, bus.mem_en, bus.busy, bus.i_rdata});
      end
    end
    bus.i_req = 1; bus.i_addr = 32'h3000; mem_val = 32'hCAFEF00D;
    step(); step(); step();
    total++;
    if ({bus.i_done, bus.i_rdata} !== {1'b1, 32'hCAFEF00D}) begin
      bad++; $display("FAIL flush_next got %h want 1_cafef00d", {bus.i_done, bus.i_rdata});
    end
    bus.i_req = 0;
    step();
  endtask
  task automatic test_rst_mid_d();
    bus.d_req = 1; bus.d_we = 0; bus.d_addr = 32'h40; mem_val = 32'h12345678;
    step();
    total++;
    if ({bus.mem_en, bus.mem_addr} !== {1'b1, 32'h40}) begin
      bad++; $display("FAIL rst_mid_grant got %h want 1_00000040", {bus.mem_en, bus.mem_addr});
    end
    #3 rst = 1;
    #1;
    total++;
    if ({bus.mem_en, bus.busy, bus.mem_addr, bus.i_rdata, bus.d_done} !== 67'd0) begin
      bad++; $display("FAIL rst_mid_async got %h want 0", {bus.mem_en, bus.busy, bus.mem_addr, bus.i_rdata, bus.d_done});
    end
    bus.d_req = 0;
    step();
    rst = 0;
    for (int k = 0; k < 3; k++) begin
      step();
      total++;
      if ({bus.d_done, bus.busy} !== 2'b00) begin
        bad++; $display("FAIL rst_mid_nodone cyc%0d got %b want 00", k, {bus.d_done, bus.busy});
      end
    end
    bus.d_req = 1;
    step(); step(); step();
    total++;
    if ({bus.d_done, bus.d_rdata} !== {1'b1, 32'h12345678}) begin
      bad++; $display("FAIL rst_mid_reissue got %h want 1_12345678", {bus.d_done, bus.d_rdata});
    end
    bus.d_req = 0;
    step();
  endtask
  task automatic test_store();
    bus.d_req = 1; bus.d_we = 1; bus.d_addr = 32'h20; bus.d_wdata = 32'h55AA; bus.d_wstrb = 4'h3;
    step();
    total++;
    if ({bus.mem_en, bus.mem_we, bus.mem_addr, bus.mem_wdata, bus.mem_wstrb, bus.d_done} !== {2'b11, 32'h20, 32'h55AA, 4'h3, 1'b0}) begin
      bad++; $display("FAIL store_issue got %h want 3_00000020_000055aa_3_0",
                      {bus.mem_en, bus.mem_we, bus.mem_addr, bus.mem_wdata, bus.mem_wstrb, bus.d_done});
    end
    step();
    total++;
    if ({bus.d_done, bus.mem_en, bus.mem_we, bus.busy, bus.d_rdata} !== {4'b1000, 32'h12345678}) begin
      bad++; $display("FAIL store_done got %h want 8_12345678", {bus.d_done, bus.mem_en, bus.mem_we, bus.busy, bus.d_rdata});
    end
    bus.d_req = 0; bus.d_we = 0;
    step();
  endtask
  task automatic test_flush_idle();
    bus.i_req = 1; bus.i_flush = 1; bus.i_addr = 32'h4000;
    for (int k = 0; k < 3; k++) begin
      step();
      total++;
      if ({bus.mem_en, bus.busy} !== 2'b00) begin
        bad++; $display("FAIL flush_idle cyc%0d got %b want 00", k, {bus.mem_en, bus.busy});
      end
    end
    bus.i_req = 0; bus.i_flush = 0;
  endtask
  task automatic test_back_to_back();
    int nd, ni;
    nd = 0; ni = 0;
    use_model = 1;
    rst = 1;
    bus.i_req = 1; bus.i_addr = 32'h100; bus.d_req = 1; bus.d_we = 0; bus.d_addr = 32'h200;
    step();
    rst = 0;
    for (int k = 1; k <= 12; k++) begin
      step();
      nd += int'(bus.d_done);
      ni += int'(bus.i_done);
      total++;
      if ({bus.d_done, bus.i_done} !== {k % 6 == 3, k % 6 == 0}) begin
        bad++; $display("FAIL rr_done cyc%0d got %b want %b", k, {bus.d_done, bus.i_done}, {k % 6 == 3, k % 6 == 0});
      end
      if (k % 3 == 1) begin
        total++;
        if ({bus.mem_en, bus.mem_addr} !== {1'b1, (k % 6 == 1) ? 32'h200 : 32'h100}) begin
          bad++; $display("FAIL rr_grant cyc%0d got %h want %h", k, {bus.mem_en, bus.mem_addr},
                          {1'b1, (k % 6 == 1) ? 32'h200 : 32'h100});
        end
      end
      if (k == 3 || k == 6) begin
        total++;
        if ((k == 3 ? bus.d_rdata : bus.i_rdata) !== (k == 3 ? (32'h200 ^ K) : (32'h100 ^ K))) begin
          bad++; $display("FAIL rr_data cyc%0d got %h want %h", k, k == 3 ? bus.d_rdata : bus.i_rdata,
                          k == 3 ? (32'h200 ^ K) : (32'h100 ^ K));
        end
      end
    end
    total++;
    if ({nd, ni} !== {32'd2, 32'd2}) begin
      bad++; $display("FAIL rr_count got d=%0d i=%0d want d=2 i=2", nd, ni);
    end
    bus.i_req = 0; bus.d_req = 0;
    use_model = 0;
  endtask
  initial begin
    test_reset();
    test_i_read();
    test_flush();
    test_rst_mid_d();
    test_store();
    test_flush_idle();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
